// File: rtl/ex_s2p.sv
// Serial-to-parallel frame receiver: hunts for a 1100 preamble, shifts in a 17-bit
// payload and 4-bit CRC, and reports decoded fields with CRC/format status and statistics.
module ex_s2p #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdata_i,
  input  logic             cnt_clr_i,
  output logic             rx_valid_o,
  output logic             rx_rnw_o,
  output logic [7:0]       rx_addr_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_crc_err_o,
  output logic             rx_fmt_err_o,
  output logic             sync_err_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] crc_err_cnt_o
);

  typedef enum logic [1:0] {StHunt, StPre, StPayload, StCrc} state_e;

  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [16:0]       payload_q, payload_d;
  logic [2:0]        crc_sr_q, crc_sr_d;
  logic              frame_done;
  logic              pre_exp;
  logic [3:0]        crc_rx, crc_exp;

  logic              rx_valid_q, rx_valid_d;
  logic              sync_err_q, sync_err_d;
  logic              rx_rnw_q, rx_rnw_d;
  logic [7:0]        rx_addr_q, rx_addr_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_crc_err_q, rx_crc_err_d;
  logic              rx_fmt_err_q, rx_fmt_err_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  crc_err_cnt_q, crc_err_cnt_d;

  // Preamble bit 1 must be 1; bits 2 and 3 must be 0.
  assign pre_exp = (bit_cnt_q == 5'd1);

  // The last CRC bit is compared straight from the line so the frame completes on bit 24.
  assign crc_rx = {crc_sr_q, sdata_i};

  assign crc_exp[0] = payload_q[15] ^ payload_q[11] ^ payload_q[10] ^ payload_q[9] ^
                      payload_q[8] ^ payload_q[6] ^ payload_q[4] ^ payload_q[3] ^
                      payload_q[0] ^ 1'b1;
  assign crc_exp[1] = payload_q[16] ^ payload_q[15] ^ payload_q[12] ^ payload_q[8] ^
                      payload_q[7] ^ payload_q[6] ^ payload_q[5] ^ payload_q[3] ^
                      payload_q[1] ^ payload_q[0];
  assign crc_exp[2] = payload_q[16] ^ payload_q[13] ^ payload_q[9] ^ payload_q[8] ^
                      payload_q[7] ^ payload_q[6] ^ payload_q[4] ^ payload_q[2] ^
                      payload_q[1] ^ 1'b1;
  assign crc_exp[3] = payload_q[14] ^ payload_q[10] ^ payload_q[9] ^ payload_q[8] ^
                      payload_q[7] ^ payload_q[5] ^ payload_q[3] ^ payload_q[2];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    payload_d  = payload_q;
    crc_sr_d   = crc_sr_q;
    sync_err_d = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      StHunt: begin
        if (sdata_i) begin
          state_d   = StPre;
          bit_cnt_d = 5'd1;
        end
      end
      StPre: begin
        if (sdata_i != pre_exp) begin
          state_d    = StHunt;
          bit_cnt_d  = '0;
          sync_err_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd3) state_d = StPayload;
        end
      end
      StPayload: begin
        payload_d = {payload_q[15:0], sdata_i};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd20) state_d = StCrc;
      end
      StCrc: begin
        crc_sr_d = {crc_sr_q[1:0], sdata_i};
        if (bit_cnt_q == 5'd24) begin
          frame_done = 1'b1;
          state_d    = StHunt;
          bit_cnt_d  = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      default: begin
        state_d   = StHunt;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    rx_valid_d    = frame_done;
    rx_rnw_d      = rx_rnw_q;
    rx_addr_d     = rx_addr_q;
    rx_data_d     = rx_data_q;
    rx_crc_err_d  = rx_crc_err_q;
    rx_fmt_err_d  = rx_fmt_err_q;
    frame_cnt_d   = frame_cnt_q;
    crc_err_cnt_d = crc_err_cnt_q;
    if (frame_done) begin
      rx_rnw_d     = payload_q[16];
      rx_addr_d    = payload_q[15:8];
      rx_data_d    = payload_q[7:0];
      rx_crc_err_d = (crc_rx != crc_exp);
      rx_fmt_err_d = payload_q[16] && (payload_q[7:0] != 8'h5A);
    end
    // Clear wins over an increment landing in the same cycle.
    if (cnt_clr_i) begin
      frame_cnt_d   = '0;
      crc_err_cnt_d = '0;
    end else if (rx_valid_q) begin
      if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
      if (rx_crc_err_q && (crc_err_cnt_q != '1)) crc_err_cnt_d = crc_err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      bit_cnt_q     <= '0;
      payload_q     <= '0;
      crc_sr_q      <= '0;
      rx_valid_q    <= 1'b0;
      sync_err_q    <= 1'b0;
      rx_rnw_q      <= 1'b0;
      rx_addr_q     <= '0;
      rx_data_q     <= '0;
      rx_crc_err_q  <= 1'b0;
      rx_fmt_err_q  <= 1'b0;
      frame_cnt_q   <= '0;
      crc_err_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      payload_q     <= payload_d;
      crc_sr_q      <= crc_sr_d;
      rx_valid_q    <= rx_valid_d;
      sync_err_q    <= sync_err_d;
      rx_rnw_q      <= rx_rnw_d;
      rx_addr_q     <= rx_addr_d;
      rx_data_q     <= rx_data_d;
      rx_crc_err_q  <= rx_crc_err_d;
      rx_fmt_err_q  <= rx_fmt_err_d;
      frame_cnt_q   <= frame_cnt_d;
      crc_err_cnt_q <= crc_err_cnt_d;
    end
  end

  assign rx_valid_o    = rx_valid_q;
  assign sync_err_o    = sync_err_q;
  assign rx_rnw_o      = rx_rnw_q;
  assign rx_addr_o     = rx_addr_q;
  assign rx_data_o     = rx_data_q;
  assign rx_crc_err_o  = rx_crc_err_q;
  assign rx_fmt_err_o  = rx_fmt_err_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign crc_err_cnt_o = crc_err_cnt_q;

endmodule

// File: tb/tb_ex_s2p.sv
// Scoreboard bench for ex_s2p: stimulus queues expected frames and sync errors with due
// cycles; a negedge monitor pops and compares fields, pulses and statistics counters.
module tb_ex_s2p;

  localparam int unsigned CNT_W = 8;
  localparam int CntMax = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sdata_i;
  logic             cnt_clr_i;
  logic             rx_valid_o;
  logic             rx_rnw_o;
  logic [7:0]       rx_addr_o;
  logic [7:0]       rx_data_o;
  logic             rx_crc_err_o;
  logic             rx_fmt_err_o;
  logic             sync_err_o;
  logic [CNT_W-1:0] frame_cnt_o;
  logic [CNT_W-1:0] crc_err_cnt_o;

  ex_s2p #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sdata_i      (sdata_i),
    .cnt_clr_i    (cnt_clr_i),
    .rx_valid_o   (rx_valid_o),
    .rx_rnw_o     (rx_rnw_o),
    .rx_addr_o    (rx_addr_o),
    .rx_data_o    (rx_data_o),
    .rx_crc_err_o (rx_crc_err_o),
    .rx_fmt_err_o (rx_fmt_err_o),
    .sync_err_o   (sync_err_o),
    .frame_cnt_o  (frame_cnt_o),
    .crc_err_cnt_o(crc_err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       due;
    bit       rnw;
    bit [7:0] addr;
    bit [7:0] data;
    bit       crc_err;
    bit       fmt_err;
  } exp_t;

  exp_t exp_q[$];
  int   sync_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC taken directly from the bit equations over payload d16..d0.
  function automatic logic [3:0] ref_crc(input logic [16:0] d);
    logic [3:0] c;
    c[0] = d[15] ^ d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[6] ^ d[4] ^ d[3] ^ d[0] ^ 1'b1;
    c[1] = d[16] ^ d[15] ^ d[12] ^ d[8] ^ d[7] ^ d[6] ^ d[5] ^ d[3] ^ d[1] ^ d[0];
    c[2] = d[16] ^ d[13] ^ d[9] ^ d[8] ^ d[7] ^ d[6] ^ d[4] ^ d[2] ^ d[1] ^ 1'b1;
    c[3] = d[14] ^ d[10] ^ d[9] ^ d[8] ^ d[7] ^ d[5] ^ d[3] ^ d[2];
    return c;
  endfunction

  // Monitor: expected output state, and statistics as plain saturating integers.
  exp_t     r;
  bit       e_rnw = 0, e_crc = 0, e_fmt = 0;
  bit [7:0] e_addr = 0, e_data = 0;
  int       m_frame = 0, m_crc = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rx_valid_o === 1'b1) begin
        n_checks++;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
          r = exp_q.pop_front();
          e_rnw = r.rnw; e_addr = r.addr; e_data = r.data;
          e_crc = r.crc_err; e_fmt = r.fmt_err;
        end else begin
          n_errs++;
          $display("FAIL rx_valid_unexpected: got pulse at cycle %0d expected due %0d", cyc,
                   (exp_q.size() != 0) ? exp_q[0].due : -1);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        check("rx_valid_missing", 32'(rx_valid_o), 32'd1);
        void'(exp_q.pop_front());
      end
      if (sync_err_o === 1'b1) begin
        n_checks++;
        if (sync_q.size() != 0 && sync_q[0] == cyc) void'(sync_q.pop_front());
        else begin
          n_errs++;
          $display("FAIL sync_err_unexpected: got pulse at cycle %0d expected none", cyc);
        end
      end else if (sync_q.size() != 0 && sync_q[0] <= cyc) begin
        check("sync_err_missing", 32'(sync_err_o), 32'd1);
        void'(sync_q.pop_front());
      end
      check("rx_rnw", 32'(rx_rnw_o), 32'(e_rnw));
      check("rx_addr", 32'(rx_addr_o), 32'(e_addr));
      check("rx_data", 32'(rx_data_o), 32'(e_data));
      check("rx_crc_err", 32'(rx_crc_err_o), 32'(e_crc));
      check("rx_fmt_err", 32'(rx_fmt_err_o), 32'(e_fmt));
      check("frame_cnt", 32'(frame_cnt_o), 32'(m_frame));
      check("crc_err_cnt", 32'(crc_err_cnt_o), 32'(m_crc));
      if (rst_n === 1'b0) begin
        m_frame = 0; m_crc = 0;
        e_rnw = 0; e_addr = 0; e_data = 0; e_crc = 0; e_fmt = 0;
      end else if (cnt_clr_i === 1'b1) begin
        m_frame = 0; m_crc = 0;
      end else if (rx_valid_o === 1'b1) begin
        if (m_frame < CntMax) m_frame++;
        if (e_crc && m_crc < CntMax) m_crc++;
      end
    end
  end

  task automatic idle(input int n);
    sdata_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_raw(input logic [24:0] f, input bit rnw, input bit [7:0] a,
                          input bit [7:0] d, input bit ce, input bit fe);
    exp_t e;
    for (int i = 24; i >= 0; i--) begin
      sdata_i = f[i];
      if (i == 0) begin
        e.due = cyc + 1; e.rnw = rnw; e.addr = a; e.data = d;
        e.crc_err = ce; e.fmt_err = fe;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input bit rnw, input bit [7:0] a, input bit [7:0] d,
                            input bit [3:0] crc_xor);
    logic [16:0] p;
    p = {rnw, a, d};
    send_raw({4'b1100, p, ref_crc(p) ^ crc_xor}, rnw, a, d, crc_xor != 4'd0,
             rnw && (d != 8'h5A));
  endtask

  task automatic send_frag(input logic [3:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdata_i = pat[i];
      if (i == 0) sync_q.push_back(cyc + 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_frame(input bit allow_crc_err);
    bit [7:0] d;
    bit [3:0] x;
    d = ($urandom_range(0, 3) == 0) ? 8'h5A : 8'($urandom);
    x = (allow_crc_err && $urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    send_frame(1'($urandom), 8'($urandom), d, x);
  endtask

  logic [24:0] part;

  initial begin
    rst_n = 1'b0; sdata_i = 1'b0; cnt_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_valid", 32'(rx_valid_o), 32'd0);
    check("reset_sync_err", 32'(sync_err_o), 32'd0);
    check("reset_rx_addr", 32'(rx_addr_o), 32'd0);
    check("reset_frame_cnt", 32'(frame_cnt_o), 32'd0);
    mon_en = 1'b1;
    rst_n = 1'b1;

    // Write addr 0x12 data 0x34.
    send_raw(25'h1812349, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    idle(1);
    check("write_frame_cnt", 32'(frame_cnt_o), 32'd1);
    idle(2);

    // Read followed back-to-back by write.
    send_raw(25'h19125A3, 1'b1, 8'h12, 8'h5A, 1'b0, 1'b0);
    send_raw(25'h1812349, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    idle(2);

    // Flipped CRC bit.
    send_raw(25'h1812348, 1'b0, 8'h12, 8'h34, 1'b1, 1'b0);
    idle(1);
    check("crc_err_cnt_one", 32'(crc_err_cnt_o), 32'd1);
    idle(1);

    // Preamble fragment 1,0 then idle, then a good frame.
    send_frag(4'b0010, 2);
    idle(4);
    send_frame(1'b1, 8'hA5, 8'h77, 4'd0);
    idle(2);

    // Reset after frame bit 12 discards the partial frame.
    part = 25'h1812349;
    for (int i = 24; i >= 12; i--) begin
      sdata_i = part[i];
      @(posedge clk); #1;
    end
    rst_n = 1'b0; sdata_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_reset_frame_cnt", 32'(frame_cnt_o), 32'd0);
    send_raw(25'h1812349, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    idle(1);
    check("post_reset_frame_cnt", 32'(frame_cnt_o), 32'd1);

    // Randomized mix of frames, preamble fragments and gaps.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0: send_frag(4'b0010, 2);
        1: send_frag(4'b0111, 3);
        2: send_frag(4'b1101, 4);
        default: rand_frame(1'b1);
      endcase
      idle($urandom_range(0, 3));
    end

    // Saturation then clear coincident with the 257th rx_valid.
    cnt_clr_i = 1'b1;
    idle(1);
    cnt_clr_i = 1'b0;
    for (int k = 0; k < 256; k++) rand_frame(1'b0);
    idle(1);
    check("sat_frame_cnt", 32'(frame_cnt_o), 32'd255);
    rand_frame(1'b0);
    cnt_clr_i = 1'b1;
    check("clr_coincident_valid", 32'(rx_valid_o), 32'd1);
    idle(1);
    cnt_clr_i = 1'b0;
    check("clr_frame_cnt", 32'(frame_cnt_o), 32'd0);
    idle(5);

    check("pending_frames", 32'(exp_q.size()), 32'd0);
    check("pending_sync_errs", 32'(sync_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
